busca_instrucao: RTL and testbench

Instruction fetch and issue unit for the nRISC core: it walks the program counter and reads 8-bit instructions from instruction memory over a req/ack handshake. It presents each instruction, with its 3-bit opcode, to the control unit's decode stage over a valid/ready handshake. The unit applies taken-branch redirects from the execute stage and parks itself permanently once a halt instruction is accepted. It is the producer side of the opcode path that the control unit consumes.

---
 rtl/busca_instrucao.sv | 217 +++++++++++++++++++++
 tb/tb_busca_instrucao.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch and issue unit for the nRISC core.
//
// Walks the program counter, reads instructions from instruction memory over a
// req/ack handshake and presents them, with their 3-bit opcode, to decode over a
// valid/ready handshake. Taken branches from execute redirect the PC on accept;
// an accepted halt instruction (opcode 110, instr[1:0] = 11) parks the unit
// until reset.
//
// Optional feature: define BUSCA_PREFETCH_EN for a one-entry prefetch buffer that
// keeps fetching while an instruction waits in ISSUE (1 instr/cycle sustained).
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req/addr            fetch request and address (addr stable while req)
//   imem_ack/data            memory response, data valid with ack
//   instr_valid/instr/opcode/instr_pc  instruction presented to decode
//   instr_ready              decode accepts when instr_valid is high
//   br_taken/br_target       redirect, sampled only in the accept cycle
//   halted                   halt instruction accepted, unit idle
module busca_instrucao #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               halted
);

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StIssue  = 2'd1,
    StHalted = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  // Held low for the first cycle after reset so imem_req is 0 while in reset
  // and the first request starts one clock after release.
  logic               run_q;
  logic               is_halt;
  logic               accept;

  assign instr       = instr_q;
  assign opcode      = instr_q[7:5];
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == StIssue);
  assign halted      = (state_q == StHalted);
  assign accept      = instr_valid & instr_ready;
  assign is_halt     = (instr_q[7:5] == 3'b110) && (instr_q[1:0] == 2'b11);

`ifdef BUSCA_PREFETCH_EN

  logic               buf_valid_q, buf_valid_d;
  logic [INSTR_W-1:0] buf_data_q, buf_data_d;
  logic [PC_W-1:0]    buf_pc_q, buf_pc_d;
  // drop_q marks an outstanding request whose data must be thrown away after a
  // redirect or halt; hold_addr_q keeps its address stable until the ack.
  logic               drop_q, drop_d;
  logic [PC_W-1:0]    hold_addr_q, hold_addr_d;
  logic               fetch_ok;

  assign imem_req  = run_q && ((state_q == StFetch) ||
                               (state_q == StIssue && !buf_valid_q) || drop_q);
  assign imem_addr = drop_q ? hold_addr_q : pc_q;
  assign fetch_ok  = imem_req && imem_ack && !drop_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_pc_d    = buf_pc_q;
    drop_d      = drop_q;
    hold_addr_d = hold_addr_q;

    // A dropped request retires on its ack regardless of state.
    if (drop_q && imem_req && imem_ack) begin
      drop_d = 1'b0;
    end

    case (state_q)
      StFetch: begin
        if (fetch_ok) begin
          instr_d    = imem_data;
          instr_pc_d = pc_q;
          pc_d       = pc_q + PC_W'(1);
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (accept) begin
          if (is_halt || br_taken) begin
            buf_valid_d = 1'b0;
            if (imem_req && !imem_ack && !drop_q) begin
              drop_d      = 1'b1;
              hold_addr_d = pc_q;
            end
            if (is_halt) begin
              state_d = StHalted;
            end else begin
              pc_d    = br_target;
              state_d = StFetch;
            end
          end else if (buf_valid_q) begin
            instr_d     = buf_data_q;
            instr_pc_d  = buf_pc_q;
            buf_valid_d = 1'b0;
          end else if (fetch_ok) begin
            // Ack in the accept cycle bypasses the buffer.
            instr_d    = imem_data;
            instr_pc_d = pc_q;
            pc_d       = pc_q + PC_W'(1);
          end else begin
            // Request continues in FETCH with the same address.
            state_d = StFetch;
          end
        end else if (fetch_ok) begin
          buf_data_d  = imem_data;
          buf_pc_d    = pc_q;
          buf_valid_d = 1'b1;
          pc_d        = pc_q + PC_W'(1);
        end
      end
      StHalted: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_pc_q    <= '0;
      drop_q      <= 1'b0;
      hold_addr_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_pc_q    <= buf_pc_d;
      drop_q      <= drop_d;
      hold_addr_q <= hold_addr_d;
    end
  end

`else

  assign imem_req  = run_q && (state_q == StFetch);
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      StFetch: begin
        if (imem_req && imem_ack) begin
          instr_d    = imem_data;
          instr_pc_d = pc_q;
          pc_d       = pc_q + PC_W'(1);
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (accept) begin
          // Halt wins over a simultaneous branch.
          if (is_halt) begin
            state_d = StHalted;
          end else begin
            if (br_taken) begin
              pc_d = br_target;
            end
            state_d = StFetch;
          end
        end
      end
      StHalted: ;
      default: state_d = StFetch;
    endcase
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      run_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed self-checking bench for busca_instrucao (default build, no prefetch).
// Memory model acks after ack_delay cycles of imem_req; mem_en withholds acks.
module tb_busca_instrucao;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [2:0]         opcode;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               halted;

  logic [7:0] mem [256];
  int         ack_delay = 0;
  logic       mem_en    = 1'b1;
  int         wait_cnt  = 0;

  int n_tests = 0;
  int n_fail  = 0;

  busca_instrucao #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(8'h00)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .instr_valid(instr_valid),
    .instr      (instr),
    .opcode     (opcode),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign imem_ack  = mem_en && imem_req && (wait_cnt >= ack_delay);
  assign imem_data = mem[imem_addr];

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_instr(input string tag, input logic [7:0] exp_instr,
                             input logic [7:0] exp_pc);
    logic [7:0] ei;
    ei = exp_instr;
    check_eq({tag, "_valid"},  32'(instr_valid), 32'd1);
    check_eq({tag, "_instr"},  32'(instr),       32'(ei));
    check_eq({tag, "_opcode"}, 32'(opcode),      32'(ei[7:5]));
    check_eq({tag, "_pc"},     32'(instr_pc),    32'(exp_pc));
  endtask

  task automatic check_fetch(input string tag, input logic [7:0] exp_addr);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_req"},   32'(imem_req),    32'd1);
    check_eq({tag, "_addr"},  32'(imem_addr),   32'(exp_addr));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h20;
    mem[8'h01] = 8'h41;
    mem[8'h02] = 8'h62;
    mem[8'h03] = 8'hE0;
    mem[8'h10] = 8'hC2;  // opcode 110 but not a halt
    mem[8'h11] = 8'hC3;  // halt
    mem[8'h40] = 8'h11;
    mem[8'hFF] = 8'hA5;

    rst_n       = 1'b0;
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    br_target   = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_req",    32'(imem_req),    32'd0);
    check_eq("rst_addr",   32'(imem_addr),   32'd0);
    check_eq("rst_valid",  32'(instr_valid), 32'd0);
    check_eq("rst_instr",  32'(instr),       32'd0);
    check_eq("rst_opcode", 32'(opcode),      32'd0);
    check_eq("rst_pc",     32'(instr_pc),    32'd0);
    check_eq("rst_halted", 32'(halted),      32'd0);

    // Sequential fetch, zero-wait memory, one instruction every other cycle.
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk); check_fetch("f0", 8'h00);
    @(negedge clk); check_instr("i0", 8'h20, 8'h00);
    @(negedge clk); check_fetch("f1", 8'h01);
    @(negedge clk); check_instr("i1", 8'h41, 8'h01);

    // Stall: outputs frozen, no fetch, branch without accept ignored.
    instr_ready = 1'b0;
    br_taken    = 1'b1;
    br_target   = 8'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_instr("stall", 8'h41, 8'h01);
      check_eq("stall_req", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    br_taken    = 1'b0;
    @(negedge clk); check_fetch("f2", 8'h02);
    @(negedge clk); check_instr("i2", 8'h62, 8'h02);
    @(negedge clk); check_fetch("f3", 8'h03);
    @(negedge clk); check_instr("i3", 8'hE0, 8'h03);

    // Taken branch on accept.
    br_taken  = 1'b1;
    br_target = 8'h10;
    @(negedge clk);
    br_taken = 1'b0;
    check_fetch("fbr", 8'h10);
    @(negedge clk); check_instr("ibr", 8'hC2, 8'h10);
    check_eq("nohalt", 32'(halted), 32'd0);
    @(negedge clk); check_fetch("f11", 8'h11);
    @(negedge clk); check_instr("ihalt", 8'hC3, 8'h11);

    // Halt accepted together with a branch: halt wins.
    br_taken  = 1'b1;
    br_target = 8'h40;
    @(negedge clk);
    br_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("halt_halted", 32'(halted),      32'd1);
      check_eq("halt_req",    32'(imem_req),    32'd0);
      check_eq("halt_valid",  32'(instr_valid), 32'd0);
      check_eq("halt_addr",   32'(imem_addr),   32'h12);
      @(negedge clk);
    end

    // PC wrap from 0xFF to 0x00.
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst2_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); check_fetch("w0", 8'h00);
    @(negedge clk); check_instr("wi0", 8'h20, 8'h00);
    br_taken  = 1'b1;
    br_target = 8'hFF;
    @(negedge clk);
    br_taken = 1'b0;
    check_fetch("wff", 8'hFF);
    @(negedge clk); check_instr("wiff", 8'hA5, 8'hFF);
    @(negedge clk); check_fetch("wwrap", 8'h00);
    @(negedge clk); check_instr("wi00", 8'h20, 8'h00);

    // Reset while a request is outstanding and unacknowledged.
    @(negedge clk);
    mem_en = 1'b0;
    check_fetch("pend0", 8'h01);
    @(negedge clk); check_fetch("pend1", 8'h01);
    #2 rst_n = 1'b0;
    #1 check_eq("async_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    mem_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk); check_fetch("rf0", 8'h00);
    @(negedge clk); check_instr("ri0", 8'h20, 8'h00);

    // Three-cycle memory wait: address stable over four request cycles.
    ack_delay = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_fetch("slow", 8'h01);
    end
    @(negedge clk); check_instr("slowi", 8'h41, 8'h01);
    @(negedge clk); check_fetch("slow2", 8'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
